// File: rtl/matris_pkg.sv
// Shared types and constants for the matrix loader and the downstream array.
package matris_pkg;
  typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;

  localparam int MAT_SIZE  = 2;
  localparam int MAT_WIDTH = 4;
  localparam int MAT_N     = (MAT_SIZE + 1) * (MAT_SIZE + 1);
  localparam int IDX_W     = $clog2(MAT_N);

  // LSB of element [r][c] on a row-major flat bus.
  function automatic int flat_lsb(input int r, input int c);
    return (r * (MAT_SIZE + 1) + c) * MAT_WIDTH;
  endfunction
endpackage

// File: rtl/matris_loader_if.sv
// Element stream in, matrix pair out, plus framing-error strobe.
interface matris_loader_if #(
  parameter int SIZE  = 2,
  parameter int WIDTH = 4
);
  localparam int NE = (SIZE + 1) * (SIZE + 1);

  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_last;
  logic                out_valid;
  logic                out_ack;
  logic [NE*WIDTH-1:0] m1_flat;
  logic [NE*WIDTH-1:0] m2_flat;
  logic                frame_err;

  modport master (
    output in_valid, in_data, in_last, out_ack,
    input  in_ready, out_valid, m1_flat, m2_flat, frame_err
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ack,
    output in_ready, out_valid, m1_flat, m2_flat, frame_err
  );
endinterface

// File: rtl/matris_bank.sv
// DEPTH x WIDTH register file exposed as one flat row-major read bus.
module matris_bank #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IW-1:0]          widx,
  input  logic [WIDTH-1:0]       wdata,
  output logic [DEPTH*WIDTH-1:0] flat
);
  always_ff @(posedge clk) begin
    if (rst) begin
      flat <= '0;
    end else if (we) begin
      flat[widx*WIDTH +: WIDTH] <= wdata;
    end
  end
endmodule

// File: rtl/matris_loader.sv
// Streams two row-major matrices in, holds them for the consumer until acked.
module matris_loader
  import matris_pkg::*;
#(
  parameter int SIZE  = MAT_SIZE,
  parameter int WIDTH = MAT_WIDTH
) (
  input logic               clk,
  input logic               rst,
  matris_loader_if.slave    bus
);
  localparam int NE = (SIZE + 1) * (SIZE + 1);
  localparam int IW = $clog2(NE);

  state_t        state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          accept, last_idx, err_nx, we1, we2;
  logic          out_valid_q, frame_err_q;

  assign accept   = bus.in_valid && (state != HOLD);
  assign last_idx = (idx == IW'(NE - 1));

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    err_nx   = 1'b0;
    we1      = 1'b0;
    we2      = 1'b0;
    unique case (state)
      LOAD_A: if (accept) begin
        if (bus.in_last) begin
          err_nx = 1'b1;
        end else begin
          we1 = 1'b1;
          if (last_idx) begin
            idx_nx   = '0;
            state_nx = LOAD_B;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      LOAD_B: if (accept) begin
        // in_last must coincide exactly with the final m2 element
        if (bus.in_last != last_idx) begin
          err_nx = 1'b1;
        end else begin
          we2 = 1'b1;
          if (last_idx) begin
            idx_nx   = '0;
            state_nx = HOLD;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      HOLD: if (bus.out_ack) begin
        idx_nx   = '0;
        state_nx = LOAD_A;
      end
      default: state_nx = LOAD_A;
    endcase
    if (err_nx) begin
      idx_nx   = '0;
      state_nx = LOAD_A;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD_A;
      idx         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      out_valid_q <= (state_nx == HOLD);
      frame_err_q <= err_nx;
    end
  end

  assign bus.in_ready  = (state != HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;

  matris_bank #(.DEPTH(NE), .WIDTH(WIDTH), .IW(IW)) u_m1 (
    .clk   (clk),
    .rst   (rst),
    .we    (we1),
    .widx  (idx),
    .wdata (bus.in_data),
    .flat  (bus.m1_flat)
  );

  matris_bank #(.DEPTH(NE), .WIDTH(WIDTH), .IW(IW)) u_m2 (
    .clk   (clk),
    .rst   (rst),
    .we    (we2),
    .widx  (idx),
    .wdata (bus.in_data),
    .flat  (bus.m2_flat)
  );
endmodule

// File: tb/tb_matris_loader.sv
// Directed bench for matris_loader: nominal table, backpressure, framing errors, gaps, reset.
module tb_matris_loader;
  import matris_pkg::*;

  localparam int FW = MAT_N * MAT_WIDTH;

  typedef int unsigned frame_t [18];
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       l;
    logic       a;
    logic       x_ready;
    logic       x_ovalid;
    logic       x_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  matris_loader_if #(.SIZE(MAT_SIZE), .WIDTH(MAT_WIDTH)) bus ();

  matris_loader #(.SIZE(MAT_SIZE), .WIDTH(MAT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  frame_t nom = '{6, 5, 7, 8, 11, 12, 6, 6, 1, 2, 5, 3, 3, 9, 5, 2, 6, 10};
  frame_t alt = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 15, 14, 13, 12, 11, 10, 9, 8, 7};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] pack(input frame_t s, input int base);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < MAT_N; i++) begin
      r[flat_lsb(i / (MAT_SIZE + 1), i % (MAT_SIZE + 1)) +: MAT_WIDTH] = s[base + i][3:0];
    end
    return r;
  endfunction

  task automatic send_frame(input frame_t s, input bit gapped, input bit last_ok, output int ticks);
    ticks = 0;
    for (int i = 0; i < 18; i++) begin
      if (gapped && i == 17) chk("gap_ovalid_early", 64'(bus.out_valid), 64'(0));
      bus.in_valid = 1'b1;
      bus.in_data  = s[i][3:0];
      bus.in_last  = last_ok && (i == 17);
      tick();
      ticks++;
      if (gapped && i != 17) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 4'hF;
        bus.in_last  = 1'b1;
        tick();
        ticks++;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_ack();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
    chk("ack_ovalid", 64'(bus.out_valid), 64'(0));
    chk("ack_ready", 64'(bus.in_ready), 64'(1));
  endtask

  task automatic chk_bufs(input string name, input frame_t s);
    chk({name, "_m1"}, 64'(bus.m1_flat), 64'(pack(s, 0)));
    chk({name, "_m2"}, 64'(bus.m2_flat), 64'(pack(s, 9)));
  endtask

  vec_t tbl [21];
  logic [FW-1:0] snap1, snap2;
  int ticks;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.out_ack  = 1'b0;

    for (int i = 0; i < 18; i++)
      tbl[i] = '{1'b1, nom[i][3:0], (i == 17), 1'b0, (i != 17), (i == 17), 1'b0};
    tbl[18] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    tick();
    tick();
    chk("rst_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_ovalid", 64'(bus.out_valid), 64'(0));
    chk("rst_err", 64'(bus.frame_err), 64'(0));
    chk("rst_m1", 64'(bus.m1_flat), 64'(0));
    chk("rst_m2", 64'(bus.m2_flat), 64'(0));
    rst = 1'b0;

    // Nominal frame, ack on the third HOLD cycle
    for (int k = 0; k < 21; k++) begin
      bus.in_valid = tbl[k].v;
      bus.in_data  = tbl[k].d;
      bus.in_last  = tbl[k].l;
      bus.out_ack  = tbl[k].a;
      tick();
      chk($sformatf("nom_ready_%0d", k), 64'(bus.in_ready), 64'(tbl[k].x_ready));
      chk($sformatf("nom_ovalid_%0d", k), 64'(bus.out_valid), 64'(tbl[k].x_ovalid));
      chk($sformatf("nom_err_%0d", k), 64'(bus.frame_err), 64'(tbl[k].x_err));
      if (k == 17) chk_bufs("nom", nom);
    end
    bus.out_ack = 1'b0;
    chk("nom_m1_r1c1", 64'(bus.m1_flat[19:16]), 64'(4'hB));
    chk("nom_m2_r2c2", 64'(bus.m2_flat[35:32]), 64'(4'hA));

    // Backpressure with junk on the input
    send_frame(nom, 1'b0, 1'b1, ticks);
    chk("bp_ovalid0", 64'(bus.out_valid), 64'(1));
    snap1 = bus.m1_flat;
    snap2 = bus.m2_flat;
    for (int k = 0; k < 20; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 4'(k + 3);
      bus.in_last  = k[0];
      tick();
      chk("bp_ready", 64'(bus.in_ready), 64'(0));
      chk("bp_ovalid", 64'(bus.out_valid), 64'(1));
      chk("bp_m1", 64'(bus.m1_flat), 64'(snap1));
      chk("bp_m2", 64'(bus.m2_flat), 64'(snap2));
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    do_ack();

    // Early in_last on m1 element 4
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = alt[i][3:0];
      tick();
    end
    bus.in_data = 4'h3;
    bus.in_last = 1'b1;
    tick();
    chk("early_err", 64'(bus.frame_err), 64'(1));
    chk("early_ready", 64'(bus.in_ready), 64'(1));
    chk("early_ovalid", 64'(bus.out_valid), 64'(0));
    chk("early_discard", 64'(bus.m1_flat[19:16]), 64'(4'hB));
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    chk("early_err_pulse", 64'(bus.frame_err), 64'(0));
    send_frame(alt, 1'b0, 1'b1, ticks);
    chk("early_next_ovalid", 64'(bus.out_valid), 64'(1));
    chk_bufs("early_next", alt);
    do_ack();

    // Missing in_last on element 18
    send_frame(nom, 1'b0, 1'b0, ticks);
    chk("miss_err", 64'(bus.frame_err), 64'(1));
    chk("miss_ovalid", 64'(bus.out_valid), 64'(0));
    chk("miss_ready", 64'(bus.in_ready), 64'(1));
    chk("miss_discard", 64'(bus.m2_flat[35:32]), 64'(4'h7));
    tick();
    chk("miss_err_pulse", 64'(bus.frame_err), 64'(0));
    chk("miss_ovalid2", 64'(bus.out_valid), 64'(0));

    // Gapped input, also proves the loader restarted in LOAD_A at idx 0
    send_frame(nom, 1'b1, 1'b1, ticks);
    chk("gap_cycles", 64'(ticks), 64'(35));
    chk("gap_ovalid", 64'(bus.out_valid), 64'(1));
    chk_bufs("gap", nom);
    do_ack();

    // Reset after 10 accepted elements
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = alt[i][3:0];
      tick();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_m2", 64'(bus.m2_flat[3:0]), 64'(4'hF));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ovalid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_ready", 64'(bus.in_ready), 64'(1));
    chk("mid_rst_err", 64'(bus.frame_err), 64'(0));
    chk("mid_rst_m1", 64'(bus.m1_flat), 64'(0));
    chk("mid_rst_m2", 64'(bus.m2_flat), 64'(0));
    send_frame(alt, 1'b0, 1'b1, ticks);
    chk("post_rst_ovalid", 64'(bus.out_valid), 64'(1));
    chk_bufs("post_rst", alt);
    do_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matris_loader.md
# matris_loader

Serial-to-parallel front end for the matrix datapath. Accepts a stream of WIDTH-bit elements over a valid/ready handshake, assembles two (SIZE+1)×(SIZE+1) operand matrices in row-major order, and presents them as flat buses with a valid/ack handshake. Its outputs drive the element-wise sum, difference, product and transpose array directly downstream. Framing errors discard the partial frame.

## Interface
- SIZE, 2, maximum row/column index; matrix dimension is SIZE+1.
- WIDTH, 4, element width in bits.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  loader can accept an element this cycle.
- in_data  in  WIDTH  element value.
- in_last  in  1  marks the final element of the frame (last element of matrix 2).
- out_valid  out  1  both matrices complete and stable.
- out_ack  in  1  consumer has taken the matrices.
- m1_flat  out  N*WIDTH  matrix 1; N=(SIZE+1)^2; element [r][c] at bits (r*(SIZE+1)+c)*WIDTH +: WIDTH.
- m2_flat  out  N*WIDTH  matrix 2, same packing.
- frame_err  out  1  one-cycle pulse on framing error.

## Operation
- Handshake: element accepted when in_valid && in_ready.
- States: LOAD_A, LOAD_B, HOLD.
  - LOAD_A: in_ready=1; accepted element written to m1 at index idx; idx increments. On acceptance with idx=N-1: idx←0, go LOAD_B.
  - LOAD_B: in_ready=1; writes m2. On acceptance with idx=N-1 and in_last=1: go HOLD.
  - HOLD: in_ready=0, out_valid=1, m1_flat/m2_flat frozen. On out_ack=1: go LOAD_A, idx←0.
- Framing error (the accepted element is discarded):
  - in_last=1 on any accepted element other than m2 index N-1; or
  - in_last=0 on the accepted m2 index N-1.
- On framing error: frame_err pulses, idx←0, state←LOAD_A. Matrix storage is not cleared; partial contents are overwritten by the next frame.
- in_data is ignored when not accepted. out_ack is ignored outside HOLD.
- Reset values: state LOAD_A, idx 0, in_ready 1, out_valid 0, frame_err 0, m1_flat and m2_flat all zero.
- rst mid-frame or in HOLD aborts immediately to the reset values. It does not pulse frame_err.

## Timing
- All outputs are registered, except in_ready, which decodes state combinationally.
- out_valid rises the cycle after the final accepted element. It falls the cycle after out_ack is sampled high.
- in_ready returns high the cycle after the ack.
- Minimum frame period: 2N+1 cycles (19 for SIZE=2) with back-to-back in_valid and immediate ack.
- frame_err is high for exactly the cycle after the offending acceptance.
- Element written at edge k is visible on the flat bus at cycle k+1. The downstream stage consumes it only while out_valid=1.
- No combinational path from in_valid or out_ack to any output.

## Structure
- Shared package matris_pkg:
  - state enum {LOAD_A, LOAD_B, HOLD};
  - localparam N=(SIZE+1)*(SIZE+1);
  - idx width $clog2(N);
  - flat-bus index function shared with the downstream array.
- Sub-module matris_bank: N×WIDTH register file with write enable, write index and flat read bus, synchronous clear on rst. Instantiated twice (m1, m2).
- Top holds the FSM, idx counter and error logic only.

## Test plan
- Nominal frame: stream 6,5,7,8,11,12,6,6,1 then 2,5,3,3,9,5,2,6,10 with in_last on the 18th element, ack after 3 cycles.
  - Required: m1 bits[19:16]=4'hB, m2 bits[35:32]=4'hA.
  - out_valid high cycle 19 through the ack cycle+1.
  - frame_err never asserts.
- Backpressure: hold out_ack low 20 cycles, drive in_valid high with junk.
  - Required: in_ready=0 throughout; buses unchanged.
- Early in_last on m1 element 4.
  - Required: frame_err pulse; next 18 elements form a clean frame with correct values.
- Missing in_last on element 18.
  - Required: frame_err pulse; out_valid stays 0; state returns to LOAD_A.
- Gapped input: in_valid toggling 1/0 every cycle.
  - Required: same matrices as the nominal case; out_valid after 35 cycles.
- rst asserted after 10 accepted elements.
  - Required: next cycle out_valid=0, in_ready=1, buses zero; a following full frame loads correctly.
